// File: rtl/game_sequencer_if.sv
// Game-flow bus between the sequencer and the player/bar datapath.
interface game_sequencer_if;
    logic       frame_tick;
    logic       start_btn;
    logic       hit;
    logic [9:0] player_h;
    logic [9:0] level;
    logic [2:0] lives;
    logic [3:0] bar_speed;
    logic       play_en;
    logic       respawn;
    logic       game_over;
    logic       won;
    logic [2:0] state;

    modport master (
        output frame_tick, start_btn, hit, player_h,
        input  level, lives, bar_speed, play_en, respawn, game_over, won, state
    );

    modport slave (
        input  frame_tick, start_btn, hit, player_h,
        output level, lives, bar_speed, play_en, respawn, game_over, won, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow FSM: idle, play, hit-respawn, level-up, game-over; owns level/lives.
// Events sampled on one edge appear on outputs after that edge; no backpressure.
module game_sequencer #(
    parameter int LIVES_INIT    = 3,
    parameter int MAX_LEVEL     = 9,
    parameter int RESPAWN_TICKS = 60,
    parameter int LEVELUP_TICKS = 90,
    parameter int FINISH_H      = 580
) (
    input  logic              clk,
    input  logic              reset,
    game_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_HIT      = 3'd2,
        S_LEVEL_UP = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_TICKS - 1);
    localparam logic [7:0] LEVELUP_LAST = 8'(LEVELUP_TICKS - 1);
    localparam logic [9:0] LAST_LEVEL   = 10'(MAX_LEVEL);
    localparam logic [9:0] FINISH_LINE  = 10'(FINISH_H);
    localparam logic [2:0] LIVES_START  = 3'(LIVES_INIT);

    state_t     st;
    logic [9:0] level_r;
    logic [2:0] lives_r;
    logic       respawn_r;
    logic       won_r;
    logic [7:0] tick_cnt;
    logic       start_q;

    logic start_rise;
    logic finish;

    assign start_rise = bus.start_btn & ~start_q;
    assign finish     = (bus.player_h >= FINISH_LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            level_r   <= 10'd1;
            lives_r   <= LIVES_START;
            respawn_r <= 1'b0;
            won_r     <= 1'b0;
            tick_cnt  <= 8'd0;
            start_q   <= 1'b1;
        end else begin
            start_q   <= bus.start_btn;
            respawn_r <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start_rise) begin
                        st        <= S_PLAY;
                        respawn_r <= 1'b1;
                        tick_cnt  <= 8'd0;
                    end
                end
                S_PLAY: begin
                    // A hit in the same cycle as reaching the finish line wins.
                    if (bus.hit) begin
                        tick_cnt <= 8'd0;
                        if (lives_r > 3'd1) begin
                            lives_r   <= lives_r - 3'd1;
                            respawn_r <= 1'b1;
                            st        <= S_HIT;
                        end else begin
                            lives_r <= 3'd0;
                            won_r   <= 1'b0;
                            st      <= S_OVER;
                        end
                    end else if (finish) begin
                        tick_cnt <= 8'd0;
                        if (level_r < LAST_LEVEL) begin
                            level_r   <= level_r + 10'd1;
                            respawn_r <= 1'b1;
                            st        <= S_LEVEL_UP;
                        end else begin
                            won_r <= 1'b1;
                            st    <= S_OVER;
                        end
                    end
                end
                S_HIT: begin
                    // Counter parks at its terminal value while the hit persists.
                    if (bus.frame_tick) begin
                        if (tick_cnt == RESPAWN_LAST) begin
                            if (!bus.hit) begin
                                st       <= S_PLAY;
                                tick_cnt <= 8'd0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                S_LEVEL_UP: begin
                    if (bus.frame_tick) begin
                        if (tick_cnt == LEVELUP_LAST) begin
                            st       <= S_PLAY;
                            tick_cnt <= 8'd0;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (start_rise) begin
                        level_r   <= 10'd1;
                        lives_r   <= LIVES_START;
                        won_r     <= 1'b0;
                        respawn_r <= 1'b1;
                        tick_cnt  <= 8'd0;
                        st        <= S_PLAY;
                    end
                end
                default: begin
                    st       <= S_IDLE;
                    tick_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus.state     = st;
    assign bus.level     = level_r;
    assign bus.lives     = lives_r;
    assign bus.bar_speed = level_r[3:0];
    assign bus.play_en   = (st == S_PLAY);
    assign bus.respawn   = respawn_r;
    assign bus.game_over = (st == S_OVER);
    assign bus.won       = won_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench: a count-down reference model feeds a scoreboard checked by monitors.
module tb_game_sequencer;

    localparam int LIVES_INIT    = 3;
    localparam int MAX_LEVEL     = 9;
    localparam int RESPAWN_TICKS = 60;
    localparam int LEVELUP_TICKS = 90;
    localparam int FINISH_H      = 580;
    localparam int NCYCLES       = 40000;

    localparam int P_IDLE = 0, P_PLAY = 1, P_HIT = 2, P_LU = 3, P_OVER = 4;

    logic clk = 1'b0;
    logic reset;

    game_sequencer_if bus();

    game_sequencer #(
        .LIVES_INIT   (LIVES_INIT),
        .MAX_LEVEL    (MAX_LEVEL),
        .RESPAWN_TICKS(RESPAWN_TICKS),
        .LEVELUP_TICKS(LEVELUP_TICKS),
        .FINISH_H     (FINISH_H)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state;
        int level;
        int lives;
        int bar_speed;
        int play_en;
        int respawn;
        int game_over;
        int won;
    } exp_t;

    exp_t sync_q[$];
    exp_t async_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: phase plus frame ticks still owed in the current dwell.
    int m_phase, m_level, m_lives, m_left;
    bit m_won, m_resp, m_start_prev;

    function automatic exp_t snapshot();
        exp_t e;
        e.state     = m_phase;
        e.level     = m_level;
        e.lives     = m_lives;
        e.bar_speed = m_level % 16;
        e.play_en   = (m_phase == P_PLAY) ? 1 : 0;
        e.respawn   = m_resp ? 1 : 0;
        e.game_over = (m_phase == P_OVER) ? 1 : 0;
        e.won       = m_won ? 1 : 0;
        return e;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_level = 1; m_lives = LIVES_INIT; m_left = 0;
        m_won = 0; m_resp = 0; m_start_prev = 1;
    endfunction

    function automatic void model_step(bit ft, bit sb, bit ht, int ph);
        bit rise;
        rise = sb && !m_start_prev;
        m_start_prev = sb;
        m_resp = 0;
        case (m_phase)
            P_IDLE: if (rise) begin m_phase = P_PLAY; m_resp = 1; end
            P_PLAY: begin
                if (ht) begin
                    if (m_lives > 1) begin
                        m_lives--; m_resp = 1; m_phase = P_HIT; m_left = RESPAWN_TICKS;
                    end else begin
                        m_lives = 0; m_won = 0; m_phase = P_OVER;
                    end
                end else if (ph >= FINISH_H) begin
                    if (m_level < MAX_LEVEL) begin
                        m_level++; m_resp = 1; m_phase = P_LU; m_left = LEVELUP_TICKS;
                    end else begin
                        m_won = 1; m_phase = P_OVER;
                    end
                end
            end
            P_HIT: if (ft) begin
                if (m_left > 1) m_left--;
                else if (!ht) m_phase = P_PLAY;
            end
            P_LU: if (ft) begin
                if (m_left > 1) m_left--;
                else m_phase = P_PLAY;
            end
            P_OVER: if (rise) begin
                m_level = 1; m_lives = LIVES_INIT; m_won = 0; m_resp = 1; m_phase = P_PLAY;
            end
            default: m_phase = P_IDLE;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        cmp({tag, ".state"},     32'(bus.state),     e.state);
        cmp({tag, ".level"},     32'(bus.level),     e.level);
        cmp({tag, ".lives"},     32'(bus.lives),     e.lives);
        cmp({tag, ".bar_speed"}, 32'(bus.bar_speed), e.bar_speed);
        cmp({tag, ".play_en"},   32'(bus.play_en),   e.play_en);
        cmp({tag, ".respawn"},   32'(bus.respawn),   e.respawn);
        cmp({tag, ".game_over"}, 32'(bus.game_over), e.game_over);
        cmp({tag, ".won"},       32'(bus.won),       e.won);
    endtask

    // Clocked outputs: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sync_q.size() > 0) begin
                e = sync_q.pop_front();
                check_all("sync", e);
            end
        end
    end

    // Asynchronous reset: outputs must already be at reset values mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (async_q.size() > 0) begin
                e = async_q.pop_front();
                check_all("async_rst", e);
            end
        end
    end

    bit saw_win = 0, saw_lose = 0, saw_hold = 0, saw_hit_fin = 0;
    bit saw_rst_lu = 0, saw_rst_resp = 0, saw_lvl_up = 0;

    initial begin
        int  hit_left;
        int  rst_left;
        int  r;
        bit  want_rst;

        reset          = 1'b1;
        bus.start_btn  = 1'b1;
        bus.frame_tick = 1'b0;
        bus.hit        = 1'b0;
        bus.player_h   = 10'd0;
        model_reset();
        hit_left = 0;
        rst_left = 3;

        for (int cyc = 0; cyc < NCYCLES; cyc++) begin
            @(negedge clk);

            want_rst = 0;
            if (!saw_rst_lu && m_phase == P_LU && m_left == LEVELUP_TICKS - 40) begin
                want_rst = 1; saw_rst_lu = 1;
            end else if (!saw_rst_resp && m_resp && cyc > 2000) begin
                want_rst = 1; saw_rst_resp = 1;
            end else if ($urandom_range(0, 2999) == 0) begin
                want_rst = 1;
            end

            if (reset) begin
                if (rst_left > 0) rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if (want_rst) begin
                reset = 1'b1;
                rst_left = $urandom_range(1, 3);
                model_reset();
                async_q.push_back(snapshot());
            end

            bus.frame_tick = ($urandom_range(0, 1) == 0);
            if (cyc > 20 && $urandom_range(0, 39) == 0) bus.start_btn = ~bus.start_btn;
            if (hit_left == 0 && $urandom_range(0, 599) == 0) hit_left = $urandom_range(1, 160);
            bus.hit = (hit_left > 0);
            if (hit_left > 0) hit_left--;
            r = $urandom_range(0, 99);
            if (r < 4)       bus.player_h = 10'($urandom_range(FINISH_H, 1023));
            else if (r == 4) bus.player_h = 10'(FINISH_H - 1);
            else if (r == 5) bus.player_h = 10'(FINISH_H);
            else             bus.player_h = 10'($urandom_range(0, FINISH_H - 2));

            if (reset) begin
                model_reset();
            end else begin
                if (m_phase == P_HIT && m_left == 1 && bus.hit && bus.frame_tick) saw_hold = 1;
                if (m_phase == P_PLAY && bus.hit && bus.player_h >= FINISH_H) saw_hit_fin = 1;
                model_step(bus.frame_tick, bus.start_btn, bus.hit, int'(bus.player_h));
                if (m_phase == P_OVER && m_won)  saw_win  = 1;
                if (m_phase == P_OVER && !m_won) saw_lose = 1;
                if (m_phase == P_LU) saw_lvl_up = 1;
            end
            sync_q.push_back(snapshot());
        end

        @(posedge clk);
        #2;
        cmp("scoreboard_drained", 32'(sync_q.size() + async_q.size()), 0);
        cmp("cov_win", 32'(saw_win), 1);
        cmp("cov_lose", 32'(saw_lose), 1);
        cmp("cov_levelup", 32'(saw_lvl_up), 1);
        cmp("cov_hit_hold", 32'(saw_hold), 1);
        cmp("cov_hit_and_finish", 32'(saw_hit_fin), 1);
        cmp("cov_reset_mid_levelup", 32'(saw_rst_lu), 1);
        cmp("cov_reset_during_respawn", 32'(saw_rst_resp), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the bar-dodging game. It sequences the player/bar datapath through idle, play, hit-respawn, level-up and game-over phases, and owns the level and lives registers. Its `level` output feeds the collision/score block, and `bar_speed` and `play_en` gate the bar movers and the player-input logic. It consumes the collision flag and player x-position produced by that datapath.

## Interface
- `LIVES_INIT`, 3: lives loaded at game start (1..7)
- `MAX_LEVEL`, 9: last level; finishing it wins the game (1..15)
- `RESPAWN_TICKS`, 60: frame ticks spent in HIT (1..255)
- `LEVELUP_TICKS`, 90: frame ticks spent in LEVEL_UP (1..255)
- `FINISH_H`, 580: player_h at or above which the level is complete
- `clk` in 1: system clock
- `reset` in 1: reset, asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse per video frame
- `start_btn` in 1: debounced start button, level
- `hit` in 1: collision flag from the collision/score block; level, may stay high several cycles
- `player_h` in 10: player horizontal position, pixels
- `level` out 10: current level, 1..MAX_LEVEL
- `lives` out 3: remaining lives
- `bar_speed` out 4: bar movement in pixels/frame; equals level[3:0]
- `play_en` out 1: high only in PLAY; gates bar movers and player input
- `respawn` out 1: one-cycle pulse commanding the player back to the start position
- `game_over` out 1: high in OVER
- `won` out 1: high in OVER when MAX_LEVEL was completed
- `state` out 3: debug; IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, OVER=4

## Operation
- Start edge: `start_rise = start_btn & ~start_q`, where `start_q` is registered. `start_q` resets to 1, so a button held through reset does not start a game.
- The 8-bit dwell counter `tick_cnt` clears on every state entry and increments on `frame_tick`. Expiry occurs when `frame_tick && tick_cnt == N-1`, so the dwell is exactly N frame ticks. A `frame_tick` on the entry cycle is not counted.
- IDLE: `level`=1 and `lives`=LIVES_INIT held. On `start_rise`, go to PLAY and pulse `respawn`.
- PLAY:
  - If `hit`=1 and `lives`>1: `lives`-1, pulse `respawn`, go to HIT.
  - If `hit`=1 and `lives`==1: `lives`=0, go to OVER with `won`=0.
  - Else, if `player_h`>=FINISH_H and `level`<MAX_LEVEL: `level`+1, pulse `respawn`, go to LEVEL_UP.
  - Else, if `player_h`>=FINISH_H and `level`==MAX_LEVEL: go to OVER with `won`=1.
  - Priority: hit beats finish in the same cycle.
- HIT: go to PLAY on expiry of RESPAWN_TICKS, but only if `hit`=0. If `hit` is still 1, hold `tick_cnt` at its terminal value and leave on the first cycle with `hit`=0 and `frame_tick`=1. `hit` does not decrement `lives` here.
- LEVEL_UP: on expiry of LEVELUP_TICKS, go to PLAY with no further respawn. `hit` and finish are ignored.
- OVER: outputs frozen. On `start_rise`: `level`=1, `lives`=LIVES_INIT, `won`=0, pulse `respawn`, go to PLAY.
- `start_rise` is ignored in PLAY, HIT and LEVEL_UP.
- `level` never exceeds MAX_LEVEL. `lives` never underflows. No arithmetic wraps.

## Timing
- All outputs are registered, or decoded from registered state in the case of `play_en`, `game_over` and `bar_speed`.
- Reset values: state=IDLE, `level`=1, `lives`=LIVES_INIT, `bar_speed`=1, `play_en`=0, `respawn`=0, `game_over`=0, `won`=0, `tick_cnt`=0, `start_q`=1.
- An event sampled at edge k (hit, finish or start_rise) produces the new state, `lives`/`level`, and `respawn`=1 after edge k. `respawn` drops after edge k+1.
- `play_en` falls in the same cycle that state leaves PLAY, so bars freeze with zero extra latency.
- A `reset` assertion in any state, including mid-dwell or during a `respawn` pulse, forces reset values immediately without waiting for a clock. The first transition after release needs a fresh `start_rise`.

## Test plan
- Reset with `start_btn` held at 1: stays in IDLE. Release then press: PLAY, a single `respawn` pulse, `level`=1, `lives`=3, `play_en`=1.
- In PLAY, raise `hit` for 5 cycles: `lives` 3->2 once, HIT state, `play_en`=0. After 60 `frame_tick`s with `hit` low: PLAY.
- `hit` held high past 60 ticks: remains in HIT. Release `hit`: PLAY on the next `frame_tick`, with no extra life lost.
- `player_h`=580 in PLAY at `level`=3: `level`=4, `bar_speed`=4, LEVEL_UP for exactly 90 ticks, then PLAY. With `hit`=1 and `player_h`=600 in the same cycle: HIT wins and `level` is unchanged.
- Third hit at `lives`=1: `lives`=0, `game_over`=1, `won`=0, no `respawn`. Finish at `level`=9: `game_over`=1, `won`=1. `start_rise` from OVER: `level`=1, `lives`=3, PLAY.
- Assert `reset` mid-LEVEL_UP at tick 40: state, `level` and `tick_cnt` return to reset values asynchronously, and `respawn` stays 0.
